// File: rtl/circuito_projeto_uc.sv
// rtl/circuito_projeto_uc.sv - Moore control unit for the water-level measure/classify/actuate/transmit cycle
module circuito_projeto_uc #(
  parameter int MAX_DESCARTES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       fim_medida,
  input  logic       fim_classificacao,
  input  logic [2:0] medida_classificacao,
  input  logic       descartar_medida,
  input  logic       fim_carater,
  input  logic       fim_mensagem,
  input  logic       fim_1s,
  input  logic       fim_2s,
  output logic       zera,
  output logic       zera_vlv,
  output logic       conta_1s,
  output logic       conta_2s,
  output logic       mensurar,
  output logic       analisa_medida,
  output logic       envia,
  output logic       muda,
  output logic       liga_buzzer_baixa,
  output logic       liga_buzzer_alta,
  output logic       desliga_buzzers,
  output logic       abre_valvula_auto,
  output logic       fecha_valvula_auto,
  output logic       erro_sensor,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARA        = 4'h1,
    MEDE           = 4'h2,
    AGUARDA_MEDIDA = 4'h3,
    CLASSIFICA     = 4'h4,
    AGUARDA_CLASS  = 4'h5,
    DECIDE         = 4'h6,
    FALHA          = 4'h7,
    ALARME         = 4'h8,
    ATUA           = 4'h9,
    ATUA_BAIXO     = 4'hA,
    ATUA_ALTA      = 4'hB,
    TRANSMITE      = 4'hC,
    AGUARDA_TX     = 4'hD,
    PROXIMO        = 4'hE,
    ESPERA         = 4'hF
  } state_t;

  state_t     state, nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_sat;
  logic       limite;
  logic [2:0] cls;
  logic       ultimo;

  assign cnt_sat   = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;
  assign limite    = (cnt_sat >= 4'(MAX_DESCARTES));
  assign db_estado = state;

  always_comb begin
    nxt = state;
    case (state)
      INICIAL:        if (ligar) nxt = PREPARA;
      PREPARA:        nxt = MEDE;
      MEDE:           nxt = AGUARDA_MEDIDA;
      AGUARDA_MEDIDA: if (fim_medida) nxt = CLASSIFICA;
                      else if (fim_2s) nxt = FALHA;
      CLASSIFICA:     nxt = AGUARDA_CLASS;
      AGUARDA_CLASS:  if (fim_classificacao) nxt = DECIDE;
      DECIDE:         nxt = descartar_medida ? FALHA : ATUA;
      FALHA:          nxt = limite ? ALARME : ESPERA;
      ALARME:         nxt = ESPERA;
      ATUA:           nxt = (cls == 3'b001) ? ATUA_BAIXO :
                            (cls == 3'b011) ? ATUA_ALTA : TRANSMITE;
      ATUA_BAIXO:     nxt = TRANSMITE;
      ATUA_ALTA:      nxt = TRANSMITE;
      TRANSMITE:      nxt = AGUARDA_TX;
      AGUARDA_TX:     if (fim_carater) nxt = PROXIMO;
      PROXIMO:        nxt = ultimo ? ESPERA : TRANSMITE;
      ESPERA:         if (fim_1s) nxt = ligar ? PREPARA : INICIAL;
      default:        nxt = INICIAL;
    endcase
  end

  // Outputs are registered from the next state so each equals a decode of the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= INICIAL;
      cnt                <= 4'd0;
      erro_sensor        <= 1'b0;
      cls                <= 3'b000;
      ultimo             <= 1'b0;
      zera               <= 1'b1;
      zera_vlv           <= 1'b1;
      conta_1s           <= 1'b0;
      conta_2s           <= 1'b0;
      mensurar           <= 1'b0;
      analisa_medida     <= 1'b0;
      envia              <= 1'b0;
      muda               <= 1'b0;
      liga_buzzer_baixa  <= 1'b0;
      liga_buzzer_alta   <= 1'b0;
      desliga_buzzers    <= 1'b0;
      abre_valvula_auto  <= 1'b0;
      fecha_valvula_auto <= 1'b0;
    end else begin
      state <= nxt;
      if (state == AGUARDA_CLASS && fim_classificacao) cls <= medida_classificacao;
      if (state == AGUARDA_TX && fim_carater) ultimo <= fim_mensagem;
      if (state == DECIDE && !descartar_medida) begin
        cnt         <= 4'd0;
        erro_sensor <= 1'b0;
      end
      if (state == FALHA) begin
        cnt         <= cnt_sat;
        erro_sensor <= limite;
      end
      zera               <= (nxt == INICIAL) || (nxt == PREPARA) || (nxt == MEDE);
      zera_vlv           <= (nxt == INICIAL);
      conta_1s           <= (nxt == ESPERA);
      conta_2s           <= (nxt == AGUARDA_MEDIDA);
      mensurar           <= (nxt == MEDE);
      analisa_medida     <= (nxt == CLASSIFICA);
      envia              <= (nxt == TRANSMITE);
      muda               <= (nxt == PROXIMO);
      liga_buzzer_baixa  <= (nxt == ATUA_BAIXO);
      liga_buzzer_alta   <= (nxt == ALARME) || (nxt == ATUA_ALTA);
      // Reserved classes 1xx behave like normal level.
      desliga_buzzers    <= (nxt == ATUA) && ((cls == 3'b000) || cls[2]);
      abre_valvula_auto  <= (nxt == ATUA) && (cls == 3'b001);
      fecha_valvula_auto <= (nxt == ATUA) && ((cls == 3'b010) || (cls == 3'b011));
    end
  end

endmodule
